pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Consumer-side supervisor for the core PLL. Runs on the 50 MHz reference clock, drives the PLL's `rst`, qualifies its `locked` flag, and optionally measures the frequency of the 2 MHz output clock. It releases the core reset only once lock is stable and, if enabled, the measured frequency is in range. It retries failed lock attempts a bounded number of times, then reports a sticky fault.

## Interface
Parameters:
- `PLL_RST_LEN`, 16: cycles `pll_rst` is held high per attempt.
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before the attempt fails.
- `SETTLE_LEN`, 1024: cycles `locked` must stay high continuously.
- `WINDOW`, 5000: measurement window in `clk` cycles (100 us).
- `EXP_COUNT`, 200: expected `mon_clk` rising edges per window.
- `TOL`, 2: allowed absolute deviation from `EXP_COUNT`.
- `MAX_RETRY`, 3: failed attempts before FAULT.

Ports:
- `clk` in 1: 50 MHz reference clock; sole clock.
- `reset` in 1: synchronous, active-high.
- `locked` in 1: PLL lock flag; asynchronous to `clk`.
- `mon_clk` in 1: PLL 2 MHz output, sampled as data.
- `pll_rst` out 1: PLL reset.
- `sys_reset` out 1: core reset, active-high.
- `ready` out 1: high only in RUN.
- `fault` out 1: sticky failure flag.
- `retry_cnt` out 2: failed attempts so far.
- `meas_count` out 16: edge count from the last completed window.

## Operation
- Input conditioning:
  - `locked` passes through a 2-FF synchronizer to give `locked_s`.
  - `mon_clk` passes through a 2-FF synchronizer plus a third register; a rising edge is `s2 & ~s3`.
- FSM states: PLL_RST, WAIT_LOCK, SETTLE, MEASURE, RUN, FAULT. One shared 17-bit timer clears on every state entry.
- **PLL_RST:** `pll_rst`=1. Move to WAIT_LOCK when timer = `PLL_RST_LEN`-1.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s` goes to SETTLE.
  - Timer = `LOCK_TIMEOUT`-1 fails the attempt.
- **SETTLE:**
  - `~locked_s` fails the attempt.
  - Timer = `SETTLE_LEN`-1 moves to MEASURE.
- **MEASURE:**
  - Counts edges into a 16-bit saturating counter.
  - At window end (timer = `WINDOW`-1): latch `meas_count`. If `EXP_COUNT`-`TOL` ≤ count ≤ `EXP_COUNT`+`TOL`, go to RUN; otherwise fail the attempt.
  - `~locked_s` fails the attempt at once.
  - If an edge and the window end fall on the same cycle, the edge counts in the latched value.
- **RUN:**
  - `sys_reset`=0, `ready`=1, `retry_cnt` cleared to 0.
  - `~locked_s` fails the attempt.
  - With frequency check enabled, back-to-back windows keep running. An out-of-range window result fails the attempt.
- **Attempt failure:**
  - If `retry_cnt`+1 = `MAX_RETRY`, go to FAULT.
  - Otherwise increment `retry_cnt` and go to PLL_RST.
- **FAULT:** `pll_rst`=1, `sys_reset`=1, `ready`=0, `fault`=1. Left only via `reset`.
- `sys_reset`=1 in every state except RUN.

## Timing
- Reset values: `pll_rst`=1, `sys_reset`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `meas_count`=0. State is PLL_RST, timer 0, synchronizer registers 0.
- `reset` asserted mid-operation, in any state including FAULT, gives reset values on the next edge.
- All outputs are registered, decoded from the next state, so they change on the clock edge where the state changes.
- Lock-loss latency: `locked` falling to `sys_reset` rising is at most 3 `clk` cycles (2 sync + 1 register).
- Minimum `reset` release to `ready` (frequency check on, locked already high): `PLL_RST_LEN` + 3 + `SETTLE_LEN` + `WINDOW` cycles, ±1.
- Simultaneous lock loss and window end: lock loss takes priority and `meas_count` still latches.

## Configuration
- `PLL_SUP_FREQ_CHECK_EN` defined:
  - MEASURE state, edge counter and RUN-time windows are present.
  - `meas_count` is live.
- Undefined:
  - SETTLE goes directly to RUN.
  - No edge counter is synthesized.
  - `meas_count` is tied to 0.
  - Lock supervision and retry behaviour are unchanged.

## Test plan
- `locked` rises 100 cycles after reset; `mon_clk` = 2 MHz (edge every 25 cycles) -> `ready`=1 by cycle ~6145; `meas_count`=200; `retry_cnt`=0.
- `locked` never rises, `LOCK_TIMEOUT`=1000 -> three `pll_rst` pulses of 16 cycles each; then `fault`=1, `sys_reset`=1, `retry_cnt`=2, state held until `reset`.
- `locked` glitches low for 1 cycle at cycle 500 of SETTLE -> `retry_cnt`=1, new `pll_rst` pulse, then success with `ready`=1 and `retry_cnt` back to 0.
- `mon_clk` edge every 24 cycles (208 per window) -> window fails; `meas_count`=208; retry; a persistent error ends in `fault`=1.
- In RUN, `locked` drops -> `sys_reset`=1 and `ready`=0 within 3 cycles; `pll_rst` pulses for 16 cycles; re-lock returns to RUN.
- `reset` asserted during MEASURE -> next cycle all outputs equal reset values; `meas_count`=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Consumer-side supervisor for the core PLL, clocked by the 50 MHz reference.
// It pulses the PLL reset and waits for lock. Lock must then stay stable for a
// settle period. When the frequency check is built in, the PLL output edges
// are also counted over a fixed window. Only after all that is the core reset
// released. Failed attempts are retried a bounded number of times. After the
// last retry the block parks in a sticky fault state.
//
// Optional feature macro: PLL_SUP_FREQ_CHECK_EN
//   defined   : MEASURE state, edge counter and back-to-back RUN windows are
//               present, and meas_count reports the last completed window.
//   undefined : SETTLE goes straight to RUN, no edge counter is built, and
//               meas_count is tied to 0.
//
// Ports
//   clk        in   50 MHz reference clock, sole clock
//   reset      in   synchronous active-high reset
//   locked     in   PLL lock flag, asynchronous to clk
//   mon_clk    in   PLL 2 MHz output, sampled as data
//   pll_rst    out  PLL reset
//   sys_reset  out  core reset, active-high, low only in RUN
//   ready      out  high only in RUN
//   fault      out  sticky failure flag, cleared only by reset
//   retry_cnt  out  failed attempts so far (cleared in RUN)
//   meas_count out  edge count latched at the end of the last window
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int PLL_RST_LEN  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int SETTLE_LEN   = 1024,
  parameter int WINDOW       = 5000,
  parameter int EXP_COUNT    = 200,
  parameter int TOL          = 2,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        locked,
  input  logic        mon_clk,
  output logic        pll_rst,
  output logic        sys_reset,
  output logic        ready,
  output logic        fault,
  output logic [1:0]  retry_cnt,
  output logic [15:0] meas_count
);

  localparam int TIMER_W = 17;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(PLL_RST_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_LEN - 1);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         retry_q, retry_d;
  logic [1:0]         lock_sync_q, lock_sync_d;
  logic               locked_s;
  logic               attempt_fail;

  logic pll_rst_q, pll_rst_d;
  logic sys_reset_q, sys_reset_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

`ifdef PLL_SUP_FREQ_CHECK_EN
  localparam logic [2:0]         ST_MEASURE = 3'd3;
  localparam logic [TIMER_W-1:0] WIN_LAST   = TIMER_W'(WINDOW - 1);

  logic [2:0]  mon_sync_q, mon_sync_d;
  logic        mon_edge;
  logic [15:0] edge_cnt_q, edge_cnt_d, edge_cnt_next;
  logic [15:0] meas_q, meas_d;
  logic        win_end;
  logic        in_range;
`else
  logic        unused_freq;
`endif

  // Synchronizer next-values: locked gets two flops. mon_clk gets two flops
  // plus a third stage so that a rising edge is visible as s2 & ~s3.
  always_comb begin
    lock_sync_d = {lock_sync_q[0], locked};
  end

  assign locked_s = lock_sync_q[1];

`ifdef PLL_SUP_FREQ_CHECK_EN
  // Edge detection and saturating count including this cycle's edge. The
  // window-end latch uses edge_cnt_next, so an edge on the final cycle of a
  // window is still counted in that window.
  always_comb begin
    mon_sync_d    = {mon_sync_q[1:0], mon_clk};
    mon_edge      = mon_sync_q[1] & ~mon_sync_q[2];
    edge_cnt_next = edge_cnt_q;
    if (mon_edge && (edge_cnt_q != 16'hFFFF)) begin
      edge_cnt_next = edge_cnt_q + 16'd1;
    end
    in_range = (int'(edge_cnt_next) >= (EXP_COUNT - TOL)) &&
               (int'(edge_cnt_next) <= (EXP_COUNT + TOL));
    win_end  = (timer_q == WIN_LAST);
  end
`else
  assign unused_freq = mon_clk ^ (WINDOW == 0) ^ (EXP_COUNT == 0) ^ (TOL == 0);
`endif

  // Main sequencing. The shared timer counts up by default and is forced to
  // zero whenever the next state differs from the current one. Lock loss is
  // evaluated ahead of the window verdict. The window count is still latched
  // on that cycle. After the FSM decision, a failed attempt is turned into
  // either a retry or the sticky fault.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TIMER_W'(1);
    retry_d      = retry_q;
    attempt_fail = 1'b0;
`ifdef PLL_SUP_FREQ_CHECK_EN
    edge_cnt_d   = edge_cnt_q;
    meas_d       = meas_q;
`endif

    case (state_q)
      ST_PLL_RST: begin
        if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s)                     state_d      = ST_SETTLE;
        else if (timer_q == TIMEOUT_LAST) attempt_fail = 1'b1;
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (timer_q == SETTLE_LAST) begin
`ifdef PLL_SUP_FREQ_CHECK_EN
          state_d = ST_MEASURE;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef PLL_SUP_FREQ_CHECK_EN
      ST_MEASURE: begin
        edge_cnt_d = edge_cnt_next;
        if (win_end) meas_d = edge_cnt_next;
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (win_end) begin
          if (in_range) state_d      = ST_RUN;
          else          attempt_fail = 1'b1;
        end
      end
`endif
      ST_RUN: begin
`ifdef PLL_SUP_FREQ_CHECK_EN
        edge_cnt_d = edge_cnt_next;
        if (win_end) begin
          meas_d     = edge_cnt_next;
          edge_cnt_d = '0;
          timer_d    = '0;
        end
        if (!locked_s)                attempt_fail = 1'b1;
        else if (win_end && !in_range) attempt_fail = 1'b1;
`else
        timer_d = timer_q;
        if (!locked_s) attempt_fail = 1'b1;
`endif
      end
      ST_FAULT: begin
        timer_d = timer_q;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    if (attempt_fail) begin
      if (int'(retry_q) + 1 >= MAX_RETRY) begin
        state_d = ST_FAULT;
      end else begin
        retry_d = retry_q + 2'd1;
        state_d = ST_PLL_RST;
      end
    end

    if (state_d != state_q) begin
      timer_d = '0;
`ifdef PLL_SUP_FREQ_CHECK_EN
      edge_cnt_d = '0;
`endif
    end

    if (state_d == ST_RUN) retry_d = '0;

    pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  // State, timer, synchronizers and registered outputs. Outputs are decoded
  // from the next state so they move on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      timer_q     <= '0;
      retry_q     <= '0;
      lock_sync_q <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      lock_sync_q <= lock_sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

`ifdef PLL_SUP_FREQ_CHECK_EN
  // Frequency-measurement registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_sync_q <= '0;
      edge_cnt_q <= '0;
      meas_q     <= '0;
    end else begin
      mon_sync_q <= mon_sync_d;
      edge_cnt_q <= edge_cnt_d;
      meas_q     <= meas_d;
    end
  end

  assign meas_count = meas_q;
`else
  assign meas_count = '0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with shortened timing parameters. It holds a
// behavioural model of the supervisor: phases, time since phase entry, and a
// queue of edge timestamps for the window count. Every cycle the DUT outputs
// are compared against that model. Directed scenarios add literal
// expectations, and a randomized phase then follows.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int PLL_RST_LEN  = 16;
  localparam int LOCK_TIMEOUT = 1000;
  localparam int SETTLE_LEN   = 128;
  localparam int WINDOW       = 250;
  localparam int EXP_COUNT    = 10;
  localparam int TOL          = 1;
  localparam int MAX_RETRY    = 3;

`ifdef PLL_SUP_FREQ_CHECK_EN
  localparam bit FREQ = 1'b1;
`else
  localparam bit FREQ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        locked;
  logic        mon_clk;
  logic        pll_rst;
  logic        sys_reset;
  logic        ready;
  logic        fault;
  logic [1:0]  retry_cnt;
  logic [15:0] meas_count;

  int checks   = 0;
  int failures = 0;
  int mon_period = 25;
  int mon_phase  = 0;

  pll_lock_supervisor #(
    .PLL_RST_LEN (PLL_RST_LEN),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .SETTLE_LEN  (SETTLE_LEN),
    .WINDOW      (WINDOW),
    .EXP_COUNT   (EXP_COUNT),
    .TOL         (TOL),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .locked    (locked),
    .mon_clk   (mon_clk),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .meas_count(meas_count)
  );

  // 50 MHz reference clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #1800000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // mon_clk source: square wave with the selected period in clk cycles, or
  // random bits when the period is 0. It changes on the falling edge.
  initial begin
    mon_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_period == 0) begin
        mon_clk = 1'($urandom_range(0, 1));
      end else begin
        mon_phase = (mon_phase + 1) % mon_period;
        mon_clk   = (mon_phase < mon_period / 2);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Behavioural model
  // ------------------------------------------------------------------------
  typedef enum int {P_RST, P_WAIT, P_SETTLE, P_MEAS, P_RUN, P_FAULT} phase_t;

  phase_t m_phase = P_RST;
  phase_t m_nxt;
  bit     m_valid = 1'b0;
  int     m_cyc = 0;
  int     m_entry = 0;
  int     m_win_start = 0;
  int     m_retry = 0;
  int     m_meas = 0;
  int     m_elapsed;
  int     m_n;
  bit     m_lk[2];
  bit     m_mon[3];
  bit     m_ls, m_det, m_fail, m_wend, m_inr;
  int     edge_q[$];

  // One model step per rising edge. The inputs are stable there because the
  // stimulus only changes on the falling edge.
  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_valid     = 1'b1;
      m_phase     = P_RST;
      m_entry     = m_cyc;
      m_win_start = m_cyc;
      m_retry     = 0;
      m_meas      = 0;
      m_lk        = '{1'b0, 1'b0};
      m_mon       = '{1'b0, 1'b0, 1'b0};
      edge_q.delete();
    end else begin
      m_ls  = m_lk[1];
      m_det = m_mon[1] && !m_mon[2];
      m_lk[1]  = m_lk[0];
      m_lk[0]  = locked;
      m_mon[2] = m_mon[1];
      m_mon[1] = m_mon[0];
      m_mon[0] = mon_clk;

      if (FREQ && m_det && (m_phase == P_MEAS || m_phase == P_RUN)) edge_q.push_back(m_cyc);

      m_elapsed = m_cyc - m_entry - 1;
      m_wend = FREQ && (m_phase == P_MEAS || m_phase == P_RUN) &&
               (m_cyc - m_win_start == WINDOW);
      m_inr = 1'b0;
      if (m_wend) begin
        m_n    = (edge_q.size() > 65535) ? 65535 : edge_q.size();
        m_meas = m_n;
        m_inr  = (m_n >= EXP_COUNT - TOL) && (m_n <= EXP_COUNT + TOL);
      end

      m_nxt  = m_phase;
      m_fail = 1'b0;
      case (m_phase)
        P_RST:    if (m_elapsed == PLL_RST_LEN - 1) m_nxt = P_WAIT;
        P_WAIT:   if (m_ls) m_nxt = P_SETTLE;
                  else if (m_elapsed == LOCK_TIMEOUT - 1) m_fail = 1'b1;
        P_SETTLE: if (!m_ls) m_fail = 1'b1;
                  else if (m_elapsed == SETTLE_LEN - 1) m_nxt = FREQ ? P_MEAS : P_RUN;
        P_MEAS:   if (!m_ls) m_fail = 1'b1;
                  else if (m_wend) begin
                    if (m_inr) m_nxt = P_RUN;
                    else       m_fail = 1'b1;
                  end
        P_RUN:    if (!m_ls || (m_wend && !m_inr)) m_fail = 1'b1;
        default:  m_nxt = m_phase;
      endcase

      if (m_fail) begin
        if (m_retry + 1 == MAX_RETRY) m_nxt = P_FAULT;
        else begin
          m_retry++;
          m_nxt = P_RST;
        end
      end

      if (m_wend && m_nxt == m_phase) begin
        m_win_start = m_cyc;
        edge_q.delete();
      end
      if (m_nxt != m_phase) begin
        m_entry     = m_cyc;
        m_win_start = m_cyc;
        edge_q.delete();
      end
      m_phase = m_nxt;
      if (m_phase == P_RUN) m_retry = 0;
    end
  end

  // ------------------------------------------------------------------------
  // Checking helpers
  // ------------------------------------------------------------------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the model, 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      checkOutput("cycle_outputs",
                  {10'd0, pll_rst, sys_reset, ready, fault, retry_cnt, meas_count},
                  {10'd0,
                   1'(m_phase == P_RST || m_phase == P_FAULT),
                   1'(m_phase != P_RUN),
                   1'(m_phase == P_RUN),
                   1'(m_phase == P_FAULT),
                   2'(m_retry),
                   16'(m_meas)});
    end
  end

  // Drive reset/locked on the falling edge, then run n edges and return 1
  // time unit after the last one.
  task automatic applyStimulus(input bit rst, input bit lk, input int n);
    @(negedge clk);
    reset  = rst;
    locked = lk;
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic waitReady(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ready) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(ready), 32'd1);
  endtask

  task automatic waitPhase(input string name, input phase_t p, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (m_phase == p) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(m_phase == p), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"},   32'(pll_rst),    32'd1);
    checkOutput({tag, "_sys_reset"}, 32'(sys_reset),  32'd1);
    checkOutput({tag, "_ready"},     32'(ready),      32'd0);
    checkOutput({tag, "_fault"},     32'(fault),      32'd0);
    checkOutput({tag, "_retry"},     32'(retry_cnt),  32'd0);
    checkOutput({tag, "_meas"},      32'(meas_count), 32'd0);
  endtask

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  initial begin
    int lat, w, falls, w2, w3, prev_rst, since_rel;
    int periods[6];
    periods = '{0, 25, 25, 20, 26, 24};
    reset  = 1'b1;
    locked = 1'b0;

    // Reset state.
    applyStimulus(1'b1, 1'b0, 3);
    checkResetValues("reset");

    // Lock rises 100 cycles after reset, mon_clk at nominal rate.
    mon_period = 25;
    applyStimulus(1'b0, 1'b0, 100);
    applyStimulus(1'b0, 1'b1, 0);
    waitReady("nominal_ready", 2000);
    checkOutput("nominal_retry", 32'(retry_cnt), 32'd0);
    checkOutput("nominal_sys_reset", 32'(sys_reset), 32'd0);
`ifdef PLL_SUP_FREQ_CHECK_EN
    checkOutput("nominal_meas", 32'(meas_count), 32'd10);
    applyStimulus(1'b0, 1'b1, 300);
    checkOutput("run_window_ready", 32'(ready), 32'd1);
    checkOutput("run_window_meas", 32'(meas_count), 32'd10);
`else
    checkOutput("nominal_meas_tied", 32'(meas_count), 32'd0);
`endif

    // Lock loss in RUN: latency, PLL reset pulse width, then re-lock.
    applyStimulus(1'b0, 1'b0, 0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (sys_reset) begin
        lat = k;
        break;
      end
    end
    checkOutput("lockloss_latency_le3", 32'(lat >= 1 && lat <= 3), 32'd1);
    checkOutput("lockloss_ready", 32'(ready), 32'd0);
    w = pll_rst ? 1 : 0;
    for (int k = 0; k < 100 && pll_rst; k++) begin
      @(posedge clk);
      #1;
      if (pll_rst) w++;
    end
    checkOutput("lockloss_pll_rst_width", 32'(w), 32'(PLL_RST_LEN));
    applyStimulus(1'b0, 1'b1, 0);
    waitReady("relock_ready", 2000);
    checkOutput("relock_retry", 32'(retry_cnt), 32'd0);

    // Lock never arrives: three pulses, then sticky fault.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 0);
    falls = 0; w = 0; w2 = 0; w3 = 0; prev_rst = 1;
    for (int k = 0; k < 4000 && !fault; k++) begin
      @(posedge clk);
      #1;
      if (pll_rst) w++;
      if (prev_rst == 1 && !pll_rst) begin
        falls++;
        if (falls == 2) w2 = w;
        if (falls == 3) w3 = w;
        w = 0;
      end
      prev_rst = pll_rst ? 1 : 0;
    end
    checkOutput("nolock_pulses", 32'(falls), 32'd3);
    checkOutput("nolock_pulse2_width", 32'(w2), 32'd16);
    checkOutput("nolock_pulse3_width", 32'(w3), 32'd16);
    checkOutput("nolock_fault", 32'(fault), 32'd1);
    checkOutput("nolock_sys_reset", 32'(sys_reset), 32'd1);
    checkOutput("nolock_retry", 32'(retry_cnt), 32'd2);
    applyStimulus(1'b0, 1'b1, 400);
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_pll_rst", 32'(pll_rst), 32'd1);
    applyStimulus(1'b1, 1'b1, 1);
    checkResetValues("fault_cleared");

    // One-cycle lock glitch in the middle of SETTLE.
    applyStimulus(1'b0, 1'b1, 0);
    waitPhase("glitch_reach_settle", P_SETTLE, 200);
    applyStimulus(1'b0, 1'b1, 60);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("glitch_retry", 32'(retry_cnt), 32'd1);
    checkOutput("glitch_pll_rst", 32'(pll_rst), 32'd1);
    waitReady("glitch_ready", 2000);
    checkOutput("glitch_retry_cleared", 32'(retry_cnt), 32'd0);

    // Upper bound on release-to-ready with lock already high.
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 0);
    since_rel = 0;
    for (int k = 0; k < 2000 && !ready; k++) begin
      @(posedge clk);
      #1;
      since_rel++;
    end
    checkOutput("startup_latency_bound",
                32'(ready && since_rel <= PLL_RST_LEN + 4 + SETTLE_LEN + (FREQ ? WINDOW : 0)),
                32'd1);

`ifdef PLL_SUP_FREQ_CHECK_EN
    // Persistently fast output clock: every window out of range -> fault.
    mon_period = 20;
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 0);
    for (int k = 0; k < 3000 && !fault; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("fast_fault", 32'(fault), 32'd1);
    checkOutput("fast_meas_range", 32'(meas_count >= 12 && meas_count <= 13), 32'd1);
    mon_period = 25;
`endif

    // Reset in the middle of qualification.
    applyStimulus(1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b1, 0);
    waitPhase("mid_reach", FREQ ? P_MEAS : P_SETTLE, 500);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 1);
    checkResetValues("mid_reset");

    // Randomized phase, checked by the model every cycle.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 99);
      mon_period = periods[$urandom_range(0, 5)];
      if (r < 8)       applyStimulus(1'b1, 1'b1, $urandom_range(1, 3));
      else if (r < 35) applyStimulus(1'b0, 1'b0, $urandom_range(1, 6));
      else if (r < 45) applyStimulus(1'b0, 1'b0, $urandom_range(200, 1200));
      else             applyStimulus(1'b0, 1'b1, $urandom_range(100, 1500));
      applyStimulus(1'b0, 1'b1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
